// File: rtl/alu_pipe_mc_if.sv
// Handshake bundle for alu_pipe_mc: operand issue side, result side, flags.
// master drives operands and OUT_READY; slave is the ALU itself.
interface alu_pipe_mc_if #(
  parameter int WIDTH = 16
);
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALU_FUN;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] ALU_OUT;
  logic [WIDTH-1:0] ALU_OUT_HI;
  logic             Carry_Flag;
  logic             Arith_flag;
  logic             Logic_flag;
  logic             CMP_flag;
  logic             Shift_flag;
  logic             Div0_flag;

  modport master (
    output IN_VALID, A, B, ALU_FUN, OUT_READY,
    input  IN_READY, OUT_VALID, ALU_OUT, ALU_OUT_HI,
    input  Carry_Flag, Arith_flag, Logic_flag,
    input  CMP_flag, Shift_flag, Div0_flag
  );

  modport slave (
    input  IN_VALID, A, B, ALU_FUN, OUT_READY,
    output IN_READY, OUT_VALID, ALU_OUT, ALU_OUT_HI,
    output Carry_Flag, Arith_flag, Logic_flag,
    output CMP_flag, Shift_flag, Div0_flag
  );
endinterface

// File: rtl/alu_pipe_mc.sv
// Handshaked ALU with full-width high word, barrel shifts and an optional
// iterative restoring divider (enabled by macro ALU_PIPE_MC_DIV_EN).
// Ports: CLK, RST (sync, active-low), bus (alu_pipe_mc_if.slave):
//   IN_VALID/IN_READY, A, B, ALU_FUN in; OUT_VALID/OUT_READY, ALU_OUT,
//   ALU_OUT_HI, Carry/Arith/Logic/CMP/Shift/Div0 flags out.
module alu_pipe_mc #(
  parameter int WIDTH = 16
) (
  input logic          CLK,
  input logic          RST,
  alu_pipe_mc_if.slave bus
);
  localparam int SW = $clog2(WIDTH);
  localparam int DW = 2 * WIDTH;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       fun;

  assign a   = bus.A;
  assign b   = bus.B;
  assign fun = bus.ALU_FUN;

  // flag vector order: {carry, arith, logic, cmp, shift, div0}
  logic             ov_q;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] hi_q;
  logic [5:0]       flg_q;

  logic idle;
  logic in_ready;
  logic accept;
  logic div_go;
  logic div_done;

  assign in_ready = RST && idle && (!ov_q || bus.OUT_READY);
  assign accept   = bus.IN_VALID && in_ready;

  logic [DW-1:0]    prod;
  logic [WIDTH:0]   sum;
  logic [SW-1:0]    sh;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic [5:0]       r_flg;

  assign prod = DW'(a) * DW'(b);
  assign sum  = {1'b0, a} + {1'b0, b};
  assign sh   = b[SW-1:0];

  always_comb begin
    r_lo  = '0;
    r_hi  = '0;
    r_flg = '0;
    unique case (fun)
      4'b0000: begin
        r_lo  = sum[WIDTH-1:0];
        r_flg = {sum[WIDTH], 5'b10000};
      end
      4'b0001: begin
        r_lo  = a - b;
        r_flg = {a < b, 5'b10000};
      end
      4'b0010: begin
        {r_hi, r_lo} = prod;
        r_flg = 6'b010000;
      end
      4'b0011: begin
        r_flg = 6'b010000;
`ifdef ALU_PIPE_MC_DIV_EN
        // only divide-by-zero resolves here; real divides go iterative
        if (b == '0) begin
          r_lo  = '1;
          r_hi  = a;
          r_flg = 6'b010001;
        end
`endif
      end
      4'b0100: begin r_lo = a & b;    r_flg = 6'b001000; end
      4'b0101: begin r_lo = a | b;    r_flg = 6'b001000; end
      4'b0110: begin r_lo = ~(a & b); r_flg = 6'b001000; end
      4'b0111: begin r_lo = ~(a | b); r_flg = 6'b001000; end
      4'b1000: begin r_lo = a ^ b;    r_flg = 6'b001000; end
      4'b1001: begin r_lo = ~(a ^ b); r_flg = 6'b001000; end
      4'b1010: begin
        r_lo  = (a == b) ? WIDTH'(1) : '0;
        r_flg = 6'b000100;
      end
      4'b1011: begin
        r_lo  = (a > b) ? WIDTH'(2) : '0;
        r_flg = 6'b000100;
      end
      4'b1100: begin
        r_lo  = (a < b) ? WIDTH'(3) : '0;
        r_flg = 6'b000100;
      end
      4'b1101: begin r_lo = a >> sh; r_flg = 6'b000010; end
      4'b1110: begin r_lo = a << sh; r_flg = 6'b000010; end
      4'b1111: begin end
    endcase
  end

`ifdef ALU_PIPE_MC_DIV_EN
  typedef enum logic {IDLE, DIV} state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvs_q;
  logic [SW-1:0]    cnt_q;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] quo_n;
  logic             qbit;

  // restoring step: bring in next dividend bit, try subtracting divisor
  assign trial = {rem_q, dvd_q[WIDTH-1]} - {1'b0, dvs_q};
  assign qbit  = !trial[WIDTH];
  assign rem_n = qbit ? trial[WIDTH-1:0]
                      : {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
  assign quo_n = {dvd_q[WIDTH-2:0], qbit};
  assign idle  = (state_q == IDLE);

  always_ff @(posedge CLK) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    div_go   = 1'b0;
    div_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept && fun == 4'b0011 && b != '0) begin
          div_go  = 1'b1;
          state_d = DIV;
        end
      end
      DIV: begin
        if (cnt_q == SW'(WIDTH - 1)) begin
          div_done = 1'b1;
          state_d  = IDLE;
        end
      end
    endcase
  end

  // dividend register doubles as the quotient shift register
  always_ff @(posedge CLK) begin
    if (!RST) begin
      dvd_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (div_go) begin
      dvd_q <= a;
      dvs_q <= b;
      rem_q <= '0;
      cnt_q <= '0;
    end else if (state_q == DIV) begin
      dvd_q <= quo_n;
      rem_q <= rem_n;
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  assign idle     = 1'b1;
  assign div_go   = 1'b0;
  assign div_done = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RST) begin
      ov_q  <= 1'b0;
      out_q <= '0;
      hi_q  <= '0;
      flg_q <= '0;
    end else if (accept && !div_go) begin
      ov_q  <= 1'b1;
      out_q <= r_lo;
      hi_q  <= r_hi;
      flg_q <= r_flg;
`ifdef ALU_PIPE_MC_DIV_EN
    end else if (div_done) begin
      ov_q  <= 1'b1;
      out_q <= quo_n;
      hi_q  <= rem_n;
      flg_q <= 6'b010000;
`endif
    end else if (bus.OUT_READY) begin
      ov_q <= 1'b0;
    end
  end

  assign bus.IN_READY   = in_ready;
  assign bus.OUT_VALID  = ov_q;
  assign bus.ALU_OUT    = out_q;
  assign bus.ALU_OUT_HI = hi_q;
  assign bus.Carry_Flag = flg_q[5];
  assign bus.Arith_flag = flg_q[4];
  assign bus.Logic_flag = flg_q[3];
  assign bus.CMP_flag   = flg_q[2];
  assign bus.Shift_flag = flg_q[1];
  assign bus.Div0_flag  = flg_q[0];
endmodule

// File: tb/tb_alu_pipe_mc.sv
// Bench for alu_pipe_mc: directed table, multi-cycle corner sequences and
// random ops against a plain-arithmetic reference model.
module tb_alu_pipe_mc;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alu_pipe_mc_if #(.WIDTH(W)) bus ();

  alu_pipe_mc #(.WIDTH(W)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    logic [5:0]  fl;
    int          lat;
    int          lowc;
  } res_t;

  typedef struct {
    logic [3:0]  f;
    logic [15:0] a;
    logic [15:0] b;
    res_t        e;
  } vec_t;

  int nvec = 0;
  int nerr = 0;

  // flags {carry, arith, logic, cmp, shift, div0}
  function automatic res_t model(logic [3:0] f, logic [15:0] a,
                                 logic [15:0] b);
    res_t   r;
    int     ua;
    int     ub;
    int     s;
    longint p;
    ua = int'(a);
    ub = int'(b);
    r.lo = '0; r.hi = '0; r.fl = '0; r.lat = 1;
    case (f)
      4'd0: begin
        s = ua + ub;
        r.lo = 16'(s);
        r.fl = {s > 65535, 5'b10000};
      end
      4'd1: begin
        r.lo = 16'(ua - ub);
        r.fl = {ua < ub, 5'b10000};
      end
      4'd2: begin
        p = longint'(ua) * longint'(ub);
        r.lo = 16'(p);
        r.hi = 16'(p >> 16);
        r.fl = 6'b010000;
      end
      4'd3: begin
        r.fl = 6'b010000;
`ifdef ALU_PIPE_MC_DIV_EN
        if (ub == 0) begin
          r.lo = 16'hFFFF;
          r.hi = a;
          r.fl = 6'b010001;
        end else begin
          r.lo  = 16'(ua / ub);
          r.hi  = 16'(ua % ub);
          r.lat = W + 1;
        end
`endif
      end
      4'd4:  begin r.lo = a & b;    r.fl = 6'b001000; end
      4'd5:  begin r.lo = a | b;    r.fl = 6'b001000; end
      4'd6:  begin r.lo = ~(a & b); r.fl = 6'b001000; end
      4'd7:  begin r.lo = ~(a | b); r.fl = 6'b001000; end
      4'd8:  begin r.lo = a ^ b;    r.fl = 6'b001000; end
      4'd9:  begin r.lo = ~(a ^ b); r.fl = 6'b001000; end
      4'd10: begin r.lo = (ua == ub) ? 16'd1 : 16'd0; r.fl = 6'b000100; end
      4'd11: begin r.lo = (ua > ub) ? 16'd2 : 16'd0;  r.fl = 6'b000100; end
      4'd12: begin r.lo = (ua < ub) ? 16'd3 : 16'd0;  r.fl = 6'b000100; end
      4'd13: begin r.lo = 16'(ua >> (ub % 16)); r.fl = 6'b000010; end
      4'd14: begin r.lo = 16'(ua << (ub % 16)); r.fl = 6'b000010; end
      default: begin end
    endcase
    r.lowc = r.lat - 1;
    return r;
  endfunction

  function automatic res_t snap(int lat, int lowc);
    res_t r;
    r.lo = bus.ALU_OUT;
    r.hi = bus.ALU_OUT_HI;
    r.fl = {bus.Carry_Flag, bus.Arith_flag, bus.Logic_flag,
            bus.CMP_flag, bus.Shift_flag, bus.Div0_flag};
    r.lat  = lat;
    r.lowc = lowc;
    return r;
  endfunction

  function automatic vec_t mk(logic [3:0] f, logic [15:0] a, logic [15:0] b,
                              logic [15:0] lo, logic [15:0] hi,
                              logic [5:0] fl, int lat);
    vec_t v;
    v.f = f; v.a = a; v.b = b;
    v.e.lo = lo; v.e.hi = hi; v.e.fl = fl;
    v.e.lat = lat; v.e.lowc = lat - 1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", nm, got, exp);
    end
  endtask

  task automatic chkr(input string nm, input res_t g, input res_t e);
    nvec++;
    if (g.lo !== e.lo || g.hi !== e.hi || g.fl !== e.fl ||
        g.lat != e.lat || g.lowc != e.lowc) begin
      nerr++;
      $display("FAIL %s: got lo=%h hi=%h fl=%b lat=%0d low=%0d, want lo=%h hi=%h fl=%b lat=%0d low=%0d",
               nm, g.lo, g.hi, g.fl, g.lat, g.lowc,
               e.lo, e.hi, e.fl, e.lat, e.lowc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [3:0] f, input logic [15:0] a,
                        input logic [15:0] b, output res_t got);
    int n;
    int lat;
    int lowc;
    n = 0;
    bus.OUT_READY = 1'b1;
    while (!bus.IN_READY && n < 40) begin
      tick();
      n++;
    end
    if (!bus.IN_READY) begin
      nvec++;
      nerr++;
      $display("FAIL ready_timeout: IN_READY stuck low, want 1");
    end
    bus.IN_VALID = 1'b1;
    bus.ALU_FUN  = f;
    bus.A        = a;
    bus.B        = b;
    tick();
    bus.IN_VALID = 1'b0;
    bus.ALU_FUN  = 4'($urandom);
    bus.A        = 16'($urandom);
    bus.B        = 16'($urandom);
    lat  = 1;
    lowc = 0;
    while (!bus.OUT_VALID && lat < 40) begin
      if (!bus.IN_READY) lowc++;
      tick();
      lat++;
    end
    got = snap(lat, lowc);
  endtask

  vec_t tbl[16];
  res_t got;
  res_t exp;
  logic [15:0] ra;
  logic [15:0] rb;
  logic [3:0]  rf;
  int          seen;

  initial begin
    tbl[0]  = mk(4'h0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 6'b110000, 1);
    tbl[1]  = mk(4'h1, 16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 6'b110000, 1);
    tbl[2]  = mk(4'h2, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 6'b010000, 1);
    tbl[3]  = mk(4'h8, 16'hF0F0, 16'hFF00, 16'h0FF0, 16'h0000, 6'b001000, 1);
    tbl[4]  = mk(4'hE, 16'h0001, 16'h0013, 16'h0008, 16'h0000, 6'b000010, 1);
    tbl[5]  = mk(4'hB, 16'd9,    16'd4,    16'h0002, 16'h0000, 6'b000100, 1);
    tbl[6]  = mk(4'hA, 16'd5,    16'd5,    16'h0001, 16'h0000, 6'b000100, 1);
    tbl[7]  = mk(4'hC, 16'd2,    16'd7,    16'h0003, 16'h0000, 6'b000100, 1);
    tbl[8]  = mk(4'hD, 16'h8000, 16'h000F, 16'h0001, 16'h0000, 6'b000010, 1);
    tbl[9]  = mk(4'h6, 16'hFFFF, 16'h00FF, 16'hFF00, 16'h0000, 6'b001000, 1);
    tbl[10] = mk(4'h7, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 6'b001000, 1);
    tbl[11] = mk(4'hF, 16'hAAAA, 16'h5555, 16'h0000, 16'h0000, 6'b000000, 1);
    tbl[12] = mk(4'h1, 16'd5,    16'd3,    16'h0002, 16'h0000, 6'b010000, 1);
    tbl[13] = mk(4'hB, 16'd4,    16'd9,    16'h0000, 16'h0000, 6'b000100, 1);
`ifdef ALU_PIPE_MC_DIV_EN
    tbl[14] = mk(4'h3, 16'd1000, 16'd7, 16'd142,   16'd6,    6'b010000, W + 1);
    tbl[15] = mk(4'h3, 16'd1000, 16'd0, 16'hFFFF,  16'd1000, 6'b010001, 1);
`else
    tbl[14] = mk(4'h3, 16'd1000, 16'd7, 16'h0000,  16'h0000, 6'b010000, 1);
    tbl[15] = mk(4'h3, 16'd1000, 16'd0, 16'h0000,  16'h0000, 6'b010000, 1);
`endif

    bus.IN_VALID  = 1'b0;
    bus.OUT_READY = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.ALU_FUN   = '0;
    tick();
    tick();
    exp.lo = '0; exp.hi = '0; exp.fl = '0; exp.lat = 0; exp.lowc = 0;
    chkr("reset_outputs", snap(0, 0), exp);
    chk("reset_valid", 32'(bus.OUT_VALID), 32'd0);
    chk("reset_ready", 32'(bus.IN_READY), 32'd0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) begin
      run_op(tbl[i].f, tbl[i].a, tbl[i].b, got);
      chkr($sformatf("vec%0d", i), got, tbl[i].e);
    end

    // back-to-back accepts, one result per cycle
    bus.OUT_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.IN_VALID = 1'b1;
      bus.ALU_FUN  = 4'h0;
      bus.A        = 16'(i * 1000 + 7);
      bus.B        = 16'hFFF0;
      chk($sformatf("tp_ready%0d", i), 32'(bus.IN_READY), 32'd1);
      ra = bus.A;
      tick();
      exp = model(4'h0, ra, 16'hFFF0);
      chkr($sformatf("tp%0d", i), snap(1, 0), exp);
    end
    bus.IN_VALID = 1'b0;
    tick();

    // back-pressure: result held, input blocked
    bus.OUT_READY = 1'b0;
    bus.IN_VALID  = 1'b1;
    bus.ALU_FUN   = 4'h0;
    bus.A         = 16'h1111;
    bus.B         = 16'h2222;
    tick();
    bus.IN_VALID = 1'b0;
    exp = model(4'h0, 16'h1111, 16'h2222);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp_ready%0d", i), 32'(bus.IN_READY), 32'd0);
      chk($sformatf("bp_valid%0d", i), 32'(bus.OUT_VALID), 32'd1);
      chkr($sformatf("bp_hold%0d", i), snap(1, 0), exp);
    end
    bus.IN_VALID  = 1'b1;
    bus.ALU_FUN   = 4'h8;
    bus.A         = 16'hF0F0;
    bus.B         = 16'hFF00;
    bus.OUT_READY = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.IN_READY), 32'd1);
    tick();
    bus.IN_VALID = 1'b0;
    chk("bp_xor_valid", 32'(bus.OUT_VALID), 32'd1);
    exp.lo = 16'h0FF0; exp.hi = '0; exp.fl = 6'b001000;
    exp.lat = 1; exp.lowc = 0;
    chkr("bp_xor", snap(1, 0), exp);
    tick();

    // reset in the middle of a division
    bus.IN_VALID = 1'b1;
    bus.ALU_FUN  = 4'h3;
    bus.A        = 16'd1000;
    bus.B        = 16'd7;
    tick();
    bus.IN_VALID = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    exp.lo = '0; exp.hi = '0; exp.fl = '0; exp.lat = 0; exp.lowc = 0;
    chkr("abort_outputs", snap(0, 0), exp);
    chk("abort_valid", 32'(bus.OUT_VALID), 32'd0);
    chk("abort_ready_low", 32'(bus.IN_READY), 32'd0);
    rst = 1'b1;
    #1;
    chk("abort_ready_high", 32'(bus.IN_READY), 32'd1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.OUT_VALID) seen++;
    end
    chk("abort_no_result", 32'(seen), 32'd0);

    // randomized ops against the reference model
    for (int i = 0; i < 300; i++) begin
      rf = 4'($urandom_range(0, 15));
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 7) == 0) rb = ra;
      if ($urandom_range(0, 3) == 0) rb = 16'($urandom_range(0, 20));
      if (rf == 4'h3 && $urandom_range(0, 3) == 0) rb = '0;
      run_op(rf, ra, rb, got);
      chkr($sformatf("rnd%0d_f%0h_%h_%h", i, rf, ra, rb), got,
           model(rf, ra, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
